// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: bus widths, opcode field position, fetch states, opcodes.
`timescale 1ns/1ps
package mips_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INSTR_W  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_STEP  = 4;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned OP_MSB = INSTR_W - 1;
    localparam int unsigned OP_LSB = INSTR_W - OP_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'd20;
    localparam logic [OP_W-1:0] OP_JUMP = 6'd21;

    function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory req/ack port, downstream stall/redirect and IF/ID outputs.
`timescale 1ns/1ps
interface instr_fetch_if
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = mips_pkg::ADDR_W,
    parameter int unsigned INSTR_W = mips_pkg::INSTR_W
);
    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;

    logic                stall;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;

    logic                if_valid;
    logic [INSTR_W-1:0]  if_instr;
    logic [ADDR_W-1:0]   if_pc;
    logic [OP_W-1:0]     op;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  stall, redirect, redirect_pc,
        output if_valid, if_instr, if_pc, op
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output stall, redirect, redirect_pc,
        input  if_valid, if_instr, if_pc, op
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem read, single IF/ID register, stall hold and redirect flush.
// Zero-wait memory gives one instruction every two cycles; stall holds the output register.
`timescale 1ns/1ps
module instr_fetch
    import mips_pkg::*;
#(
    parameter int unsigned         ADDR_W   = mips_pkg::ADDR_W,
    parameter int unsigned         INSTR_W  = mips_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(mips_pkg::RESET_PC),
    parameter int unsigned         PC_STEP  = mips_pkg::PC_STEP
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    fetch_state_e          state;
    logic                  req_q;
    logic [ADDR_W-1:0]     pc;
    logic [ADDR_W-1:0]     addr_q;
    logic                  vld_q;
    logic [INSTR_W-1:0]    instr_q;
    logic [ADDR_W-1:0]     ipc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            pc      <= RESET_PC;
            addr_q  <= RESET_PC;
            vld_q   <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.redirect) begin
                        pc    <= bus.redirect_pc;
                        vld_q <= 1'b0;
                    end else if (!vld_q || !bus.stall) begin
                        // Launching the next read also retires the word just consumed.
                        addr_q <= pc;
                        req_q  <= 1'b1;
                        vld_q  <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.redirect) begin
                        pc <= bus.redirect_pc;
                        if (bus.imem_ack) begin
                            req_q <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= DROP;
                        end
                    end else if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        ipc_q   <= addr_q;
                        vld_q   <= 1'b1;
                        pc      <= addr_q + ADDR_W'(PC_STEP);
                        req_q   <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DROP: begin
                    // Address stays put until the stale response arrives.
                    if (bus.redirect) begin
                        pc <= bus.redirect_pc;
                    end
                    if (bus.imem_ack) begin
                        req_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.if_valid  = vld_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = ipc_q;
    assign bus.op        = vld_q ? instr_q[INSTR_W-1 -: OP_W] : '0;

    a_busy_empty: assert property (@(posedge clk) disable iff (!rst_n)
        (state == BUSY) |-> !vld_q);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural wait-state memory, scoreboard of delivered words, directed scenarios.
`timescale 1ns/1ps
module tb_instr_fetch;
    import mips_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t              sb[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                mem_wait = 0;
    int                cnt = 0;
    bit                dropping = 0;
    bit                prev_req = 0;
    bit                prev_ack = 0;
    logic [ADDR_W-1:0] prev_addr = '0;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        return INSTR_W'(h ^ 32'h0022_1820);
    endfunction

    // Memory responder and scoreboard; runs 2ns after each falling edge, after the tests drive.
    initial begin
        exp_t e;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                bus.imem_ack = 1'b0;
                cnt = 0; dropping = 0; prev_req = 0; prev_ack = 0;
                sb.delete();
            end else begin
                if (bus.imem_req) begin
                    n_cmp++;
                    if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL req_with_valid: if_valid=%b required 0", bus.if_valid); end
                end
                if (prev_req && !prev_ack && bus.imem_req) begin
                    n_cmp++;
                    if (bus.imem_addr !== prev_addr) begin n_bad++; $display("FAIL addr_stable: addr=%h required %h", bus.imem_addr, prev_addr); end
                end
                if (prev_ack) begin
                    n_cmp++;
                    if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL back_to_back: imem_req=%b required 0", bus.imem_req); end
                end
                if (bus.if_valid && (!bus.stall || bus.redirect)) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_word: pc=%h instr=%h, required no word", bus.if_pc, bus.if_instr);
                    end else begin
                        e = sb.pop_front();
                        if (!bus.redirect) begin
                            n_cmp++;
                            if (bus.if_pc !== e.pc) begin n_bad++; $display("FAIL sb_pc: got %h required %h", bus.if_pc, e.pc); end
                            n_cmp++;
                            if (bus.if_instr !== e.instr) begin n_bad++; $display("FAIL sb_instr: got %h required %h", bus.if_instr, e.instr); end
                            n_cmp++;
                            if (bus.op !== opcode_of(e.instr)) begin n_bad++; $display("FAIL sb_op: got %h required %h", bus.op, opcode_of(e.instr)); end
                        end
                    end
                end
                if (bus.imem_req && cnt >= mem_wait) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(bus.imem_addr);
                    cnt = 0;
                end else begin
                    bus.imem_ack = 1'b0;
                    cnt = bus.imem_req ? cnt + 1 : 0;
                end
                if (bus.imem_ack) begin
                    if (bus.redirect || dropping) dropping = 0;
                    else sb.push_back('{pc: bus.imem_addr, instr: bus.imem_rdata});
                end else if (bus.imem_req && bus.redirect) begin
                    dropping = 1;
                end
                prev_req  = bus.imem_req;
                prev_ack  = bus.imem_ack;
                prev_addr = bus.imem_addr;
            end
        end
    end

    task automatic test_reset();
        mem_wait = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b required 0", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_addr: got %h required %h", bus.imem_addr, RESET_PC); end
        n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b required 0", bus.if_valid); end
        n_cmp++; if (bus.if_instr !== '0) begin n_bad++; $display("FAIL rst_instr: got %h required 0", bus.if_instr); end
        n_cmp++; if (bus.if_pc !== '0) begin n_bad++; $display("FAIL rst_pc: got %h required 0", bus.if_pc); end
        n_cmp++; if (bus.op !== '0) begin n_bad++; $display("FAIL rst_op: got %h required 0", bus.op); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_req: req=%b addr=%h required 1/0", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin n_bad++; $display("FAIL first_word: valid=%b pc=%h required 1/0", bus.if_valid, bus.if_pc); end
        n_cmp++; if (bus.if_instr !== 32'h0022_1820 || bus.op !== OP_ADD) begin n_bad++; $display("FAIL first_instr: instr=%h op=%h required 00221820/0", bus.if_instr, bus.op); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL first_no_req: got %b required 0", bus.imem_req); end
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin n_bad++; $display("FAIL second_req: req=%b addr=%h required 1/4", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_wait_states();
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == 32'h8) break;
        end
        if (k == 20) begin n_cmp++; n_bad++; $display("FAIL wait_timeout: no request at 00000008"); return; end
        mem_wait = 3;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.if_valid !== 1'b0) begin
                n_bad++; $display("FAIL wait_hold%0d: req=%b addr=%h valid=%b required 1/8/0", i, bus.imem_req, bus.imem_addr, bus.if_valid);
            end
        end
        @(negedge clk);
        n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8 || bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL wait_done: valid=%b pc=%h req=%b required 1/8/0", bus.if_valid, bus.if_pc, bus.imem_req); end
        mem_wait = 0;
    endtask

    task automatic test_stall();
        int k;
        logic [ADDR_W-1:0]  hpc;
        logic [INSTR_W-1:0] hin;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.if_valid) break;
        end
        if (k == 20) begin n_cmp++; n_bad++; $display("FAIL stall_timeout: if_valid never rose"); return; end
        bus.stall = 1'b1;
        hpc = bus.if_pc; hin = bus.if_instr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== hpc || bus.if_instr !== hin || bus.imem_req !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold%0d: valid=%b pc=%h instr=%h req=%b required 1/%h/%h/0", i, bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_req, hpc, hin);
            end
        end
        bus.stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== hpc + 32'd4 || bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: req=%b addr=%h valid=%b required 1/%h/0", bus.imem_req, bus.imem_addr, bus.if_valid, hpc + 32'd4); end
    endtask

    task automatic test_redirect_busy();
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.if_valid) break;
        end
        if (k == 20) begin n_cmp++; n_bad++; $display("FAIL rdb_timeout: if_valid never rose"); return; end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h10;
        @(negedge clk);
        bus.redirect = 1'b0; mem_wait = 2;
        n_cmp++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rdb_flush: valid=%b req=%b required 0/0", bus.if_valid, bus.imem_req); end
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin n_bad++; $display("FAIL rdb_req10: req=%b addr=%h required 1/10", bus.imem_req, bus.imem_addr); end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
        @(negedge clk);
        bus.redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin n_bad++; $display("FAIL rdb_drop%0d: req=%b addr=%h required 1/10", i, bus.imem_req, bus.imem_addr); end
        end
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL rdb_discard: req=%b valid=%b required 0/0", bus.imem_req, bus.if_valid); end
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_bad++; $display("FAIL rdb_req100: req=%b addr=%h required 1/100", bus.imem_req, bus.imem_addr); end
        mem_wait = 0;
        @(negedge clk);
        n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100) begin n_bad++; $display("FAIL rdb_word100: valid=%b pc=%h required 1/100", bus.if_valid, bus.if_pc); end
    endtask

    task automatic test_redirect_ack_and_stall();
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.imem_req) break;
        end
        if (k == 20) begin n_cmp++; n_bad++; $display("FAIL rda_timeout: no request"); return; end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
        @(negedge clk);
        bus.redirect = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL rda_discard: req=%b valid=%b required 0/0", bus.imem_req, bus.if_valid); end
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin n_bad++; $display("FAIL rda_req40: req=%b addr=%h required 1/40", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40) begin n_bad++; $display("FAIL rda_word40: valid=%b pc=%h required 1/40", bus.if_valid, bus.if_pc); end
        bus.stall = 1'b1;
        @(negedge clk);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
        @(negedge clk);
        bus.redirect = 1'b0; bus.stall = 1'b0;
        n_cmp++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rds_flush: valid=%b req=%b required 0/0", bus.if_valid, bus.imem_req); end
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin n_bad++; $display("FAIL rds_req80: req=%b addr=%h required 1/80", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_drop_twice_and_wrap();
        int k;
        bit pr;
        logic [ADDR_W-1:0] a0;
        @(negedge clk);
        mem_wait = 3;
        pr = bus.imem_req;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.imem_req && !pr) break;
            pr = bus.imem_req;
        end
        if (k == 20) begin n_cmp++; n_bad++; $display("FAIL drop2_timeout: no new request"); mem_wait = 0; return; end
        a0 = bus.imem_addr;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        @(negedge clk);
        bus.redirect = 1'b0;
        @(negedge clk);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
        @(negedge clk);
        bus.redirect = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== a0) begin n_bad++; $display("FAIL drop2_hold: req=%b addr=%h required 1/%h", bus.imem_req, bus.imem_addr, a0); end
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL drop2_discard: req=%b valid=%b required 0/0", bus.imem_req, bus.if_valid); end
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin n_bad++; $display("FAIL drop2_req300: req=%b addr=%h required 1/300", bus.imem_req, bus.imem_addr); end
        mem_wait = 0;
        @(negedge clk);
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_req: req=%b addr=%h required 1/fffffffc", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_word: valid=%b pc=%h required 1/fffffffc", bus.if_valid, bus.if_pc); end
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_next: req=%b addr=%h required 1/0", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_reset_midreq();
        int k;
        mem_wait = 5;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.imem_req) break;
        end
        if (k == 20) begin n_cmp++; n_bad++; $display("FAIL rmr_timeout: no request"); mem_wait = 0; return; end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin n_bad++; $display("FAIL rmr_clear: req=%b valid=%b addr=%h required 0/0/0", bus.imem_req, bus.if_valid, bus.imem_addr); end
        @(negedge clk);
        rst_n = 1'b1; mem_wait = 0;
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin n_bad++; $display("FAIL rmr_req: req=%b addr=%h required 1/0", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h0022_1820) begin n_bad++; $display("FAIL rmr_word: valid=%b instr=%h required 1/00221820", bus.if_valid, bus.if_instr); end
    endtask

    initial begin
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        test_reset();
        test_wait_states();
        test_stall();
        test_redirect_busy();
        test_redirect_ack_and_stall();
        test_drop_twice_and_wrap();
        test_reset_midreq();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
